// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/ERET sequencer and arbiter for the single CP0 write port.
// An exception writes EPC, Cause and Status in turn, then redirects fetch to the
// handler vector. ERET clears EXL in Status and redirects to the saved EPC. MTC0
// writes from the pipeline share the port and win only in IDLE when no exception
// or ERET is being requested.
//
// Handshake: mtc0_req is a level held by the pipeline until the cycle in which
// mtc0_stall is 0. That cycle is the grant: the write goes out combinationally on
// cp0_* and the request is consumed. exc_req and eret_req are sampled only in IDLE.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [5:0]  mtc0_sel,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_stall,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic [4:0]  cp0_addrW,
  output logic [5:0]  cp0_selW,
  output logic [31:0] cp0_din,
  output logic        cp0Write,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT, E_STATUS, E_REDIRECT
  } state_t;

  state_t      state;
  logic [31:0] status_sh;
  logic [4:0]  code_l;
  logic [31:0] pc_l;
  logic        bd_l;
  logic [5:0]  hw_l;
  logic [31:0] epc_l;

  // Registered sequencer write; zero whenever the sequencer does not own the port.
  logic        seq_we;
  logic [4:0]  seq_addr;
  logic [31:0] seq_din;

  logic        mtc0_grant;

  function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, 15'b0, ip, 3'b0, code, 2'b0};
  endfunction

  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign mtc0_grant = mtc0_req & ~busy & ~exc_req & ~eret_req & ~rst;
  assign mtc0_stall = mtc0_req & (busy | exc_req | eret_req);

  // Interrupt pending: any enabled line, global enable on, not already at exception level.
  assign int_pending = (|(hw_int & status_sh[15:10])) & status_sh[0] & ~status_sh[1];

  // Write-port mux: the sequencer never drives in IDLE, so it cannot collide with a grant.
  always_comb begin
    cp0Write  = 1'b0;
    cp0_addrW = 5'd0;
    cp0_selW  = 6'd0;
    cp0_din   = 32'd0;
    if (seq_we) begin
      cp0Write  = 1'b1;
      cp0_addrW = seq_addr;
      cp0_din   = seq_din;
    end else if (mtc0_grant) begin
      cp0Write  = 1'b1;
      cp0_addrW = mtc0_addr;
      cp0_selW  = mtc0_sel;
      cp0_din   = mtc0_data;
    end
  end

  // Sequencer FSM: outputs for the next state are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      status_sh      <= STATUS_RST;
      code_l         <= 5'd0;
      pc_l           <= 32'd0;
      bd_l           <= 1'b0;
      hw_l           <= 6'd0;
      epc_l          <= 32'd0;
      seq_we         <= 1'b0;
      seq_addr       <= 5'd0;
      seq_din        <= 32'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      seq_we         <= 1'b0;
      seq_addr       <= 5'd0;
      seq_din        <= 32'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      case (state)
        IDLE: begin
          if (exc_req) begin
            code_l <= exc_code;
            pc_l   <= exc_pc;
            bd_l   <= exc_bd;
            hw_l   <= hw_int;
            flush  <= 1'b1;
            seq_we <= 1'b1;
            if (status_sh[1]) begin
              // Nested exception: keep the EPC of the outer one.
              state    <= W_CAUSE;
              seq_addr <= 5'd13;
              seq_din  <= cause_word(exc_bd, hw_int, exc_code);
            end else begin
              state    <= W_EPC;
              seq_addr <= 5'd14;
              seq_din  <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end
          end else if (eret_req) begin
            epc_l    <= epc_in;
            flush    <= 1'b1;
            seq_we   <= 1'b1;
            seq_addr <= 5'd12;
            seq_din  <= status_sh & ~32'h2;
            state    <= E_STATUS;
          end else if (mtc0_grant && mtc0_addr == 5'd12 && mtc0_sel[2:0] == 3'd0) begin
            status_sh <= mtc0_data;
          end
        end
        W_EPC: begin
          seq_we   <= 1'b1;
          seq_addr <= 5'd13;
          seq_din  <= cause_word(bd_l, hw_l, code_l);
          state    <= W_CAUSE;
        end
        W_CAUSE: begin
          seq_we   <= 1'b1;
          seq_addr <= 5'd12;
          seq_din  <= status_sh | 32'h2;
          state    <= W_STATUS;
        end
        W_STATUS: begin
          status_sh      <= status_sh | 32'h2;
          redirect_valid <= 1'b1;
          redirect_pc    <= EXC_VECTOR;
          state          <= REDIRECT;
        end
        REDIRECT: state <= IDLE;
        E_STATUS: begin
          status_sh      <= status_sh & ~32'h2;
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_l;
          state          <= E_REDIRECT;
        end
        E_REDIRECT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized checks of the CP0 exception sequencer
// against a transaction-level model of the Status register and write schedule.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, exc_bd, eret_req, mtc0_req;
  logic [4:0]  exc_code, mtc0_addr;
  logic [31:0] exc_pc, epc_in, mtc0_data;
  logic [5:0]  mtc0_sel, hw_int;
  logic        mtc0_stall, int_pending, cp0Write, flush, redirect_valid, busy;
  logic [4:0]  cp0_addrW;
  logic [5:0]  cp0_selW;
  logic [31:0] cp0_din, redirect_pc;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  // Model state: Status contents and the per-cycle expected output schedule.
  // Entry layout: {we, addr[4:0], sel[5:0], din[31:0], rv, rpc[31:0], flush}.
  logic [31:0] status_m;
  logic [77:0] exp_q[$];

  cp0_exc_ctrl #(.EXC_VECTOR(EXC_VECTOR), .STATUS_RST(STATUS_RST)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .eret_req(eret_req), .epc_in(epc_in),
    .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel),
    .mtc0_data(mtc0_data), .mtc0_stall(mtc0_stall),
    .hw_int(hw_int), .int_pending(int_pending),
    .cp0_addrW(cp0_addrW), .cp0_selW(cp0_selW), .cp0_din(cp0_din),
    .cp0Write(cp0Write), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [77:0] mk(input logic we, input logic [4:0] a, input logic [5:0] s,
                                     input logic [31:0] d, input logic rv,
                                     input logic [31:0] rp, input logic fl);
    return {we, a, s, d, rv, rp, fl};
  endfunction

  function automatic logic [31:0] model_int();
    logic any;
    any = (hw_int & status_m[15:10]) != 6'd0;
    return 32'(any && status_m[0] == 1'b1 && status_m[1] == 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [77:0] e);
    chk({tag, ".we"},    32'(cp0Write),       32'(e[77]));
    chk({tag, ".addr"},  32'(cp0_addrW),      32'(e[76:72]));
    chk({tag, ".sel"},   32'(cp0_selW),       32'(e[71:66]));
    chk({tag, ".din"},   cp0_din,             e[65:34]);
    chk({tag, ".rv"},    32'(redirect_valid), 32'(e[33]));
    chk({tag, ".rpc"},   redirect_pc,         e[32:1]);
    chk({tag, ".flush"}, 32'(flush),          32'(e[0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with no requests: nothing written, interrupt view matches model.
  task automatic idle_check(input string tag);
    @(negedge clk);
    chk_cyc(tag, mk(0, 0, 0, 0, 0, 0, 0));
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".int"}, 32'(int_pending), model_int());
    step();
  endtask

  task automatic run_mtc0(input logic [4:0] a, input logic [5:0] s, input logic [31:0] d);
    mtc0_req = 1; mtc0_addr = a; mtc0_sel = s; mtc0_data = d;
    @(negedge clk);
    chk_cyc("mtc0", mk(1, a, s, d, 0, 0, 0));
    chk("mtc0.stall", 32'(mtc0_stall), 0);
    step();
    if (a == 5'd12 && (s % 8) == 0) status_m = d;
    mtc0_req = 0;
  endtask

  // Exception: EPC (skipped at EXL), Cause, Status|EXL, then redirect to the vector.
  // With hold=1 an MTC0 is presented at acceptance and held until granted.
  task automatic run_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic [5:0] hw, input logic hold, input logic [4:0] ma,
                         input logic [31:0] md, input logic noise);
    logic [31:0] cause;
    logic        first;
    logic [77:0] e;
    first = 1;
    if (!status_m[1]) begin
      exp_q.push_back(mk(1, 14, 0, bd ? pc - 32'd4 : pc, 0, 0, 1));
      first = 0;
    end
    cause = (32'(bd) << 31) + (32'(hw) << 10) + (32'(code) << 2);
    exp_q.push_back(mk(1, 13, 0, cause, 0, 0, first));
    status_m = status_m | 32'h2;
    exp_q.push_back(mk(1, 12, 0, status_m, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1, EXC_VECTOR, 0));

    exc_req = 1; exc_code = code; exc_pc = pc; exc_bd = bd; hw_int = hw;
    if (hold) begin
      mtc0_req = 1; mtc0_addr = ma; mtc0_sel = 0; mtc0_data = md;
    end
    @(negedge clk);
    chk("exc.acc.we", 32'(cp0Write), 0);
    chk("exc.acc.busy", 32'(busy), 0);
    chk("exc.acc.stall", 32'(mtc0_stall), 32'(hold));
    step();
    exc_req = 0; exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (noise) begin
        exc_req = 1'($urandom); eret_req = 1'($urandom);
      end
      @(negedge clk);
      chk_cyc("exc.seq", e);
      chk("exc.seq.busy", 32'(busy), 1);
      if (hold) chk("exc.seq.stall", 32'(mtc0_stall), 1);
      step();
    end
    exc_req = 0; eret_req = 0;
    if (hold) begin
      @(negedge clk);
      chk_cyc("exc.mtc0grant", mk(1, ma, 0, md, 0, 0, 0));
      chk("exc.mtc0grant.stall", 32'(mtc0_stall), 0);
      step();
      if (ma == 5'd12) status_m = md;
      mtc0_req = 0;
    end
  endtask

  // ERET: Status with EXL cleared, then redirect to the EPC seen at acceptance.
  task automatic run_eret(input logic [31:0] epc);
    logic [77:0] e;
    status_m = status_m & ~32'h2;
    exp_q.push_back(mk(1, 12, 0, status_m, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1, epc, 0));
    eret_req = 1; epc_in = epc;
    @(negedge clk);
    chk("eret.acc.we", 32'(cp0Write), 0);
    step();
    eret_req = 0; epc_in = $urandom;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk_cyc("eret.seq", e);
      chk("eret.seq.busy", 32'(busy), 1);
      step();
    end
  endtask

  initial begin
    rst = 1;
    exc_req = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    eret_req = 0; epc_in = 0;
    mtc0_req = 0; mtc0_addr = 0; mtc0_sel = 0; mtc0_data = 0;
    hw_int = 0;
    status_m = STATUS_RST;

    // Reset state
    @(negedge clk);
    chk_cyc("rst", mk(0, 0, 0, 0, 0, 0, 0));
    chk("rst.busy", 32'(busy), 0);
    chk("rst.int", 32'(int_pending), 0);
    chk("rst.state", 32'(state_dbg), 0);
    step();
    rst = 0;
    idle_check("idle0");

    // MTC0 to Status in IDLE, then an enabled interrupt line
    run_mtc0(5'd12, 6'd0, 32'h0000_FC01);
    hw_int = 6'b000001;
    @(negedge clk);
    chk("int.enabled", 32'(int_pending), 1);
    step();
    hw_int = 0;

    // Exception in a delay slot from EXL=0
    run_exc(5'd4, 32'h8000_0100, 1'b1, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    hw_int = 6'b000001;
    idle_check("post_exc");

    // Nested exception with MTC0 presented at acceptance and held while busy
    run_exc(5'd8, 32'h8000_0200, 1'b0, 6'd0, 1'b1, 5'd11, 32'h1234_5678, 1'b0);

    // ERET re-enables the interrupt
    run_eret(32'h8000_0104);
    hw_int = 6'b000001;
    idle_check("post_eret");
    chk("post_eret.status", status_m, 32'h0000_FC01);

    // Reset in the middle of an exception sequence
    hw_int = 0;
    exc_req = 1; exc_code = 5'd2; exc_pc = 32'h8000_0300; exc_bd = 0;
    step();
    exc_req = 0;
    step();
    #2 rst = 1;
    #1;
    chk_cyc("midrst", mk(0, 0, 0, 0, 0, 0, 0));
    chk("midrst.busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.rv", 32'(redirect_valid), 0);
      chk("midrst.we", 32'(cp0Write), 0);
    end
    step();
    rst = 0;
    status_m = STATUS_RST;
    hw_int = 6'h3F;
    for (int i = 0; i < 4; i++) idle_check("after_rst");
    // Status back at reset value: EXL clear, so EPC is written again
    run_exc(5'd1, 32'h8000_0400, 1'b0, 6'h3F, 1'b0, 5'd0, 32'd0, 1'b0);
    run_eret(32'h8000_0404);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      int kind;
      hw_int = 6'($urandom);
      idle_check("rnd.idle");
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        run_exc(5'($urandom), $urandom, 1'($urandom), 6'($urandom),
                1'($urandom), 5'($urandom), $urandom, 1'b1);
      end else if (kind == 1) begin
        run_eret($urandom);
      end else begin
        logic [4:0] a;
        a = ($urandom_range(0, 1) == 0) ? 5'd12 : 5'($urandom);
        run_mtc0(a, 6'($urandom_range(0, 9)), $urandom);
      end
    end
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
